// File: rtl/psum_pack.sv
// psum_pack: per-channel accumulator that sits downstream of the pe.
// It sums signed partial results for each lane across the input-channel loop,
// packs the four lane sums into one 64-bit word and writes that word to the
// output block RAM through a single-cycle write port. One pe result is
// accepted every cycle, and the block never stalls.
module psum_pack #(
  parameter int DATA_W = 16,
  parameter int LANES  = 4,
  parameter int ADDR_W = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [ADDR_W-1:0]             base_addr,
  input  logic                          in_valid,
  input  logic [DATA_W-1:0]             in_data,
  input  logic [$clog2(LANES)-1:0]      in_chan,
  input  logic                          in_first,
  input  logic                          in_last,
  input  logic                          flush,
  output logic                          out_ena,
  output logic [LANES*DATA_W/8-1:0]     out_wea,
  output logic [ADDR_W-1:0]             out_addr,
  output logic [LANES*DATA_W-1:0]       out_dina,
  output logic                          ovf,
  output logic                          err
);

  localparam int CHAN_W  = $clog2(LANES);
  localparam int WORD_W  = LANES * DATA_W;
  localparam int BE_W    = WORD_W / 8;
  localparam int LANE_BE = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, ACCUM, WRITE} state_t;

  state_t                    state, state_next;
  logic signed [DATA_W-1:0]  acc [LANES];
  logic [LANES-1:0]          done, loaded;
  logic [ADDR_W-1:0]         ptr;
  logic [BE_W-1:0]           wea_q;

  logic [LANES-1:0]          chan_bit, done_next;
  logic                      bad_in, take, trigger, sat_hi, sat_lo, sat_any;
  logic [DATA_W:0]           sum_ext;
  logic [DATA_W-1:0]         lane_new, lane_val;
  logic [WORD_W-1:0]         packed_word;
  logic [BE_W-1:0]           packed_wea;

  // Classify this cycle's input, form the saturated lane update and decide whether a word goes out.
  always_comb begin
    chan_bit          = '0;
    chan_bit[in_chan] = 1'b1;
    bad_in  = in_valid && !start &&
              (((done & chan_bit) != '0) || (!in_first && ((loaded & chan_bit) == '0)));
    take    = in_valid && !start && !bad_in;
    sum_ext = {acc[in_chan][DATA_W-1], acc[in_chan]} + {in_data[DATA_W-1], in_data};
    sat_hi  = !sum_ext[DATA_W] && sum_ext[DATA_W-1];
    sat_lo  = sum_ext[DATA_W] && !sum_ext[DATA_W-1];
    if (in_first)
      lane_new = in_data;
    else if (sat_hi)
      lane_new = {1'b0, {(DATA_W-1){1'b1}}};
    else if (sat_lo)
      lane_new = {1'b1, {(DATA_W-1){1'b0}}};
    else
      lane_new = sum_ext[DATA_W-1:0];
    sat_any   = take && !in_first && (sat_hi || sat_lo);
    done_next = done | ((take && in_last) ? chan_bit : '0);
    trigger   = !start && ((done_next == '1) || (flush && (done_next != '0)));
    packed_word = '0;
    packed_wea  = '0;
    lane_val    = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_val = (take && (in_chan == CHAN_W'(i))) ? lane_new : acc[i];
      packed_word[(LANES-1-i)*DATA_W +: DATA_W] = done_next[i] ? lane_val : '0;
      packed_wea[(LANES-1-i)*LANE_BE +: LANE_BE] = {LANE_BE{done_next[i]}};
    end
  end

  // Lane accumulators, completion flags, word pointer, latched write word and sticky status.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LANES; i++) acc[i] <= '0;
      done     <= '0;
      loaded   <= '0;
      ptr      <= '0;
      wea_q    <= '0;
      out_addr <= '0;
      out_dina <= '0;
      ovf      <= 1'b0;
      err      <= 1'b0;
    end else if (start) begin
      for (int i = 0; i < LANES; i++) acc[i] <= '0;
      done   <= '0;
      loaded <= '0;
      ptr    <= base_addr;
      ovf    <= 1'b0;
      err    <= 1'b0;
    end else begin
      if (bad_in)  err <= 1'b1;
      if (sat_any) ovf <= 1'b1;
      if (trigger) begin
        out_dina <= packed_word;
        wea_q    <= packed_wea;
        out_addr <= ptr;
        ptr      <= ptr + 1'b1;
        for (int i = 0; i < LANES; i++) acc[i] <= '0;
        done   <= '0;
        loaded <= '0;
      end else if (take) begin
        acc[in_chan]    <= lane_new;
        done            <= done_next;
        loaded[in_chan] <= 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state: start wins, a trigger always leads to the one-cycle write, otherwise track activity.
  always_comb begin
    state_next = state;
    if (start)
      state_next = IDLE;
    else if (trigger)
      state_next = WRITE;
    else begin
      case (state)
        IDLE:    if (take) state_next = ACCUM;
        ACCUM:   state_next = ACCUM;
        WRITE:   state_next = take ? ACCUM : IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Write strobes are only driven in the write cycle; address and data simply hold.
  always_comb begin
    out_ena = (state == WRITE);
    out_wea = (state == WRITE) ? wea_q : '0;
  end

endmodule

// File: tb/tb_psum_pack.sv
// tb_psum_pack: scoreboard bench for psum_pack. A driver issues one input per
// cycle and runs a lane-level reference model; expected writes are queued and a
// negedge monitor pops and compares them whenever the DUT strobes out_ena.
module tb_psum_pack;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  base_addr;
  logic        in_valid;
  logic [15:0] in_data;
  logic [1:0]  in_chan;
  logic        in_first, in_last, flush;
  logic        out_ena;
  logic [7:0]  out_wea;
  logic [7:0]  out_addr;
  logic [63:0] out_dina;
  logic        ovf, err;

  typedef struct {
    int          cyc;
    logic [7:0]  addr;
    logic [7:0]  wea;
    logic [63:0] dina;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  bit   mon_on = 1'b0;

  int   m_acc [4];
  bit   m_done [4];
  bit   m_loaded [4];
  int   m_ptr;
  bit   m_ovf, m_err;

  psum_pack #(.DATA_W(16), .LANES(4), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_data(in_data), .in_chan(in_chan),
    .in_first(in_first), .in_last(in_last), .flush(flush),
    .out_ena(out_ena), .out_wea(out_wea), .out_addr(out_addr),
    .out_dina(out_dina), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic modelClear();
    for (int i = 0; i < 4; i++) begin
      m_acc[i] = 0; m_done[i] = 0; m_loaded[i] = 0;
    end
  endtask

  // Reference model: lane sums as plain integers, clamped to the 16-bit signed range.
  task automatic modelStep(input bit st, input logic [7:0] base, input bit v, input logic [15:0] d,
                           input logic [1:0] ch, input bit f, input bit l, input bit fl);
    int   s;
    int   ndone;
    exp_t e;
    if (st) begin
      modelClear();
      m_ptr = int'(base);
      m_ovf = 0;
      m_err = 0;
      return;
    end
    if (v) begin
      if (m_done[ch] || (!f && !m_loaded[ch])) begin
        m_err = 1;
      end else begin
        if (f) s = int'($signed(d));
        else   s = m_acc[ch] + int'($signed(d));
        if (s > 32767)  begin s = 32767;  m_ovf = 1; end
        if (s < -32768) begin s = -32768; m_ovf = 1; end
        m_acc[ch]    = s;
        m_loaded[ch] = 1;
        if (l) m_done[ch] = 1;
      end
    end
    ndone = 0;
    for (int i = 0; i < 4; i++) ndone += m_done[i];
    if (ndone == 4 || (fl && ndone > 0)) begin
      e.cyc  = cyc + 1;
      e.addr = 8'(m_ptr);
      e.wea  = '0;
      e.dina = '0;
      for (int i = 0; i < 4; i++) begin
        if (m_done[i]) begin
          e.dina[(3-i)*16 +: 16] = 16'(m_acc[i]);
          e.wea[(3-i)*2 +: 2]    = 2'b11;
        end
      end
      sbq.push_back(e);
      m_ptr = (m_ptr + 1) % 256;
      modelClear();
    end
  endtask

  // Drive one cycle of inputs, advance the model, then check the sticky flags after the edge.
  task automatic applyStimulus(input bit st, input logic [7:0] base, input bit v, input logic [15:0] d,
                               input logic [1:0] ch, input bit f, input bit l, input bit fl);
    start = st; base_addr = base; in_valid = v; in_data = d;
    in_chan = ch; in_first = f; in_last = l; flush = fl;
    modelStep(st, base, v, d, ch, f, l, fl);
    @(posedge clk);
    #1;
    checkOutput("ovf", {63'd0, ovf}, {63'd0, m_ovf});
    checkOutput("err", {63'd0, err}, {63'd0, m_err});
  endtask

  task automatic idleCycle();
    applyStimulus(0, 8'h00, 0, 16'h0000, 2'd0, 0, 0, 0);
  endtask

  task automatic laneIn(input logic [1:0] ch, input logic [15:0] d, input bit f, input bit l);
    applyStimulus(0, 8'h00, 1, d, ch, f, l, 0);
  endtask

  task automatic doStart(input logic [7:0] base);
    applyStimulus(1, base, 0, 16'h0000, 2'd0, 0, 0, 0);
  endtask

  // Monitor: every write strobe must match the head of the scoreboard, in the expected cycle.
  always @(negedge clk) begin
    if (mon_on) begin
      if (out_ena === 1'b1) begin
        if (sbq.size() == 0) begin
          checkOutput("unexpected_write", {56'd0, out_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          checkOutput("write_cycle", 64'(cyc), 64'(e.cyc));
          checkOutput("out_addr", {56'd0, out_addr}, {56'd0, e.addr});
          checkOutput("out_wea", {56'd0, out_wea}, {56'd0, e.wea});
          checkOutput("out_dina", out_dina, e.dina);
        end
      end else begin
        checkOutput("idle_wea", {56'd0, out_wea}, 64'd0);
      end
    end
  end

  initial begin
    logic [15:0] d;
    logic [1:0]  ch;
    bit          f, l, fl, st, v;

    start = 0; base_addr = 0; in_valid = 0; in_data = 0;
    in_chan = 0; in_first = 0; in_last = 0; flush = 0;
    modelClear();
    m_ptr = 0; m_ovf = 0; m_err = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_out_ena", {63'd0, out_ena}, 64'd0);
    checkOutput("rst_out_wea", {56'd0, out_wea}, 64'd0);
    checkOutput("rst_out_addr", {56'd0, out_addr}, 64'd0);
    checkOutput("rst_out_dina", out_dina, 64'd0);
    checkOutput("rst_ovf", {63'd0, ovf}, 64'd0);
    checkOutput("rst_err", {63'd0, err}, 64'd0);
    rst = 1'b0;
    mon_on = 1'b1;

    $display("[TB] single-partial word at base 10");
    doStart(8'h10);
    for (int i = 0; i < 4; i++) laneIn(2'(i), 16'(i + 1), 1, 1);
    idleCycle();
    checkOutput("t1_dina_spec", out_dina, 64'h0001_0002_0003_0004);

    $display("[TB] interleaved three-partial lanes");
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < 4; i++) laneIn(2'(i), 16'(5 + p), p == 0, p == 2);
    idleCycle();
    checkOutput("t2_dina_spec", out_dina, 64'h0012_0012_0012_0012);
    checkOutput("t2_addr_spec", {56'd0, out_addr}, 64'h11);

    $display("[TB] saturation both directions");
    laneIn(2'd2, 16'h7FF0, 1, 0);
    laneIn(2'd0, 16'h0001, 1, 1);
    laneIn(2'd1, 16'h0001, 1, 1);
    laneIn(2'd3, 16'h0001, 1, 1);
    laneIn(2'd2, 16'h0020, 0, 1);
    idleCycle();
    checkOutput("t3_pos_sat", {48'd0, out_dina[31:16]}, 64'h7FFF);
    laneIn(2'd2, 16'h8010, 1, 0);
    laneIn(2'd2, 16'hFFC0, 0, 1);
    for (int i = 0; i < 4; i++) if (i != 2) laneIn(2'(i), 16'h0002, 1, 1);
    idleCycle();
    checkOutput("t3_neg_sat", {48'd0, out_dina[31:16]}, 64'h8000);

    $display("[TB] partial flush and empty flush");
    laneIn(2'd0, 16'hAAAA, 1, 1);
    laneIn(2'd1, 16'hBBBB, 1, 1);
    laneIn(2'd2, 16'h1234, 1, 0);
    applyStimulus(0, 8'h00, 0, 16'h0000, 2'd0, 0, 0, 1);
    idleCycle();
    checkOutput("t4_dina_spec", out_dina, 64'hAAAA_BBBB_0000_0000);
    applyStimulus(0, 8'h00, 0, 16'h0000, 2'd0, 0, 0, 1);
    idleCycle();
    applyStimulus(0, 8'h00, 1, 16'h0042, 2'd3, 1, 1, 1);
    idleCycle();

    $display("[TB] back-to-back words across pointer wrap");
    doStart(8'hFF);
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < 4; i++) laneIn(2'(i), 16'($urandom), 1, 1);
    idleCycle();
    checkOutput("t5_wrap_addr", {56'd0, out_addr}, 64'h00);

    $display("[TB] protocol errors and mid-word start");
    laneIn(2'd0, 16'h0005, 1, 0);
    laneIn(2'd1, 16'h0007, 1, 1);
    laneIn(2'd1, 16'h0100, 0, 0);
    laneIn(2'd3, 16'h0100, 0, 1);
    doStart(8'h40);
    for (int i = 0; i < 4; i++) laneIn(2'(i), 16'(16'h0010 * (i + 1)), 1, 1);
    doStart(8'h80);
    idleCycle();

    $display("[TB] randomized traffic");
    for (int n = 0; n < 3000; n++) begin
      st = ($urandom_range(0, 199) == 0);
      v  = ($urandom_range(0, 9) < 8);
      ch = 2'($urandom_range(0, 3));
      if (!m_loaded[ch]) f = ($urandom_range(0, 19) != 0);
      else               f = ($urandom_range(0, 9) == 0);
      l  = ($urandom_range(0, 2) == 0);
      fl = ($urandom_range(0, 24) == 0);
      d  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255) - 128);
      applyStimulus(st, 8'($urandom), v, d, ch, f, l, fl);
    end
    repeat (3) idleCycle();
    checkOutput("sb_drained", 64'(sbq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
